// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / restoring divide with HI/LO; 33 cycles accept-to-result, MTHI/MTLO write in 1.
// No input backpressure: start is dropped while busy or on abort, so the hazard unit must stall on busy.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div, neg_q, neg_r, div0;

  logic        load, step, fix, mthi, mtlo;
  logic        signed_op;
  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum, rem_sh;
  logic [31:0] rem_diff;
  logic        rem_ge;
  logic [63:0] mul_nxt, div_nxt, prod_res;
  logic [31:0] quo_res, rem_res;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          mthi = (op == 3'b100);
          mtlo = (op == 3'b101);
          if (!op[2]) begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == 5'd31) state_nxt = FIX;
        end
      end
      FIX: begin
        fix       = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops iterate on magnitudes; signs are restored in FIX.
  always_comb begin
    signed_op = ~op[0];
    abs_rs    = (signed_op && rs[31]) ? -rs : rs;
    abs_rt    = (signed_op && rt[31]) ? -rt : rt;

    // acc = {partial product, remaining multiplier bits}
    mul_sum = {1'b0, acc[63:32]} + {1'b0, opnd};
    mul_nxt = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};

    // acc = {partial remainder, dividend bits shifting into quotient}
    rem_sh   = acc[63:31];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh[31:0] - opnd;
    div_nxt  = rem_ge ? {rem_diff, acc[30:0], 1'b1} : {rem_sh[31:0], acc[30:0], 1'b0};

    prod_res = neg_q ? -acc : acc;
    quo_res  = div0 ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
    // With a zero divisor the remainder is |rs|, so this also restores the raw rs.
    rem_res  = neg_r ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= fix;
      if (load) begin
        cnt    <= 5'd0;
        is_div <= op[1];
        neg_q  <= signed_op & (rs[31] ^ rt[31]);
        neg_r  <= signed_op & op[1] & rs[31];
        div0   <= op[1] & (rt == 32'd0);
        acc    <= {32'd0, op[1] ? abs_rs : abs_rt};
        opnd   <= op[1] ? abs_rt : abs_rs;
      end else if (step) begin
        cnt <= cnt + 5'd1;
        acc <= is_div ? div_nxt : mul_nxt;
      end
      if (fix) begin
        if (is_div) begin
          hi <= rem_res;
          lo <= quo_res;
        end else begin
          {hi, lo} <= prod_res;
        end
      end else if (mthi) begin
        hi <= rs;
      end else if (mtlo) begin
        lo <= rs;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (o)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 15);
      4: v = -$urandom_range(1, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Caller is at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rs = $urandom;
    rt = $urandom;
  endtask

  // Counts cycles with busy high; stops at the first idle sample (bounded).
  task automatic wait_idle(output int lat, output bit early);
    lat = 0;
    early = 1'b0;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      if (done === 1'b1) early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  vop [8] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] va  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100,
                             32'h8000_0000, 32'd5, 32'd7, 32'hFFFF_FFFB};
    logic [31:0] vb  [8] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0,
                             32'hFFFF_FFFE, 32'd0};
    logic [31:0] ehi [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0,
                             32'd5, 32'd1, 32'hFFFF_FFFB};
    logic [31:0] elo [8] = '{32'h0000_0001, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int lat;
    bit early;
    for (int i = 0; i < 8; i++) begin
      issue(vop[i], va[i], vb[i]);
      wait_idle(lat, early);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d want=33", i, lat); end
      n_checks++; if (early) begin n_fail++; $display("FAIL dir%0d_done_early got=1 want=0", i); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got=%b want=1", i, done); end
      n_checks++; if (hi !== ehi[i]) begin n_fail++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, ehi[i]); end
      n_checks++; if (lo !== elo[i]) begin n_fail++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, elo[i]); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got=%b want=0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat;
    bit early;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = pick();
      b = pick();
      exp = ref_model(o, a, b);
      issue(o, a, b);
      wait_idle(lat, early);
      n_checks++; if (lat != 33 || early || done !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_timing lat=%0d early=%b done=%b want lat=33 early=0 done=1", i, lat, early, done);
      end
      n_checks++; if ({hi, lo} !== exp) begin
        n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, o, a, b, hi, lo, exp[63:32], exp[31:0]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    bit early;
    issue(3'b101, 32'h0000_ABCD, 32'd0);
    n_checks++; if (lo !== 32'h0000_ABCD) begin n_fail++; $display("FAIL mtlo_lo got=%h want=0000abcd", lo); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtlo_flags busy=%b done=%b want 0 0", busy, done); end
    issue(3'b100, 32'h5555_AAAA, 32'd0);
    n_checks++; if (hi !== 32'h5555_AAAA) begin n_fail++; $display("FAIL mthi_hi got=%h want=5555aaaa", hi); end
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    n_checks++; if (hi !== 32'h5555_AAAA || lo !== 32'h0000_ABCD || busy !== 1'b0) begin
      n_fail++; $display("FAIL nop_ignored hi=%h lo=%h busy=%b want 5555aaaa 0000abcd 0", hi, lo, busy);
    end
    issue(3'b001, 32'd3, 32'd5);
    issue(3'b100, 32'h0000_1234, 32'd0);
    n_checks++; if (hi !== 32'h5555_AAAA || busy !== 1'b1) begin
      n_fail++; $display("FAIL mthi_busy_ignored hi=%h busy=%b want 5555aaaa 1", hi, busy);
    end
    wait_idle(lat, early);
    n_checks++; if (lat != 32 || hi !== 32'd0 || lo !== 32'd15) begin
      n_fail++; $display("FAIL mthi_busy_result lat=%0d hi=%h lo=%h want 32 0 f", lat, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit seen;
    issue(3'b100, 32'h1111_1111, 32'd0);
    issue(3'b101, 32'h2222_2222, 32'd0);
    issue(3'b010, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_run_busy got=%b want=0", busy); end
    n_checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_fail++; $display("FAIL abort_run_hilo got=%h_%h want=11111111_22222222", hi, lo);
    end
    // Abort landing on the FIX cycle must still suppress the write.
    issue(3'b011, 32'd50, 32'd7);
    repeat (32) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_fix_pre_busy got=%b want=1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen || busy !== 1'b0) begin n_fail++; $display("FAIL abort_fix_done seen=%b busy=%b want 0 0", seen, busy); end
    n_checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_fail++; $display("FAIL abort_fix_hilo got=%h_%h want=11111111_22222222", hi, lo);
    end
  endtask

  task automatic test_start_abort();
    abort = 1'b1;
    issue(3'b010, 32'd9, 32'd2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy got=%b want=0", busy); end
    issue(3'b100, 32'hCAFE_0000, 32'd0);
    abort = 1'b0;
    n_checks++; if (hi !== 32'h1111_1111) begin n_fail++; $display("FAIL start_abort_mthi got=%h want=11111111", hi); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit early;
    issue(3'b001, 32'd6, 32'd7);
    wait_idle(lat, early);
    n_checks++; if (done !== 1'b1 || lo !== 32'd42) begin n_fail++; $display("FAIL b2b_first done=%b lo=%h want 1 2a", done, lo); end
    issue(3'b011, 32'd100, 32'd9);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy=%b want=1", busy); end
    wait_idle(lat, early);
    n_checks++; if (lat != 33 || done !== 1'b1 || hi !== 32'd1 || lo !== 32'd11) begin
      n_fail++; $display("FAIL b2b_second lat=%0d done=%b hi=%h lo=%h want 33 1 1 b", lat, done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    issue(3'b100, 32'hAAAA_0001, 32'd0);
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL reset_mid_done got=1 want=0"); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    op = 3'd0; rs = 32'd0; rt = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_abort();
    test_start_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
